// File: rtl/mem_access_unit.sv
// Memory stage: byte/half/word loads and stores to a local data array, with a
// fixed MEM_LATENCY wait per aligned access and registered MEM/WB outputs.
module mem_access_unit #(
    parameter int DEPTH       = 64,
    parameter int MEM_LATENCY = 2,
    parameter int DEST_W      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              wb_en,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [1:0]        size,
    input  logic              load_unsigned,
    input  logic [31:0]       pc,
    input  logic [31:0]       alu_res,
    input  logic [31:0]       st_value,
    input  logic [DEST_W-1:0] dest,
    output logic              stall,
    output logic              out_valid,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic              misalign_out,
    output logic [31:0]       pc_out,
    output logic [31:0]       alu_res_out,
    output logic [31:0]       mem_data_out,
    output logic [DEST_W-1:0] dest_out
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state, state_next;
    logic [3:0]    cnt, cnt_next;
    logic [31:0]   mem [DEPTH];

    logic          access, aligned, misaligned, mem_op;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word, wr_data, load_val;
    logic [3:0]    be;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;

    assign access     = in_valid & (mem_r_en | mem_w_en);
    assign misaligned = access & ~aligned;
    assign idx        = alu_res[AW+1:2];
    assign rd_word    = mem[idx];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        aligned = 1'b1;
        case (size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~alu_res[0];
            default: aligned = (alu_res[1:0] == 2'b00);
        endcase
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall      = 1'b0;
        mem_op     = 1'b0;
        case (state)
            IDLE: begin
                if (access && aligned) begin
                    if (MEM_LATENCY == 0) begin
                        mem_op = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        state_next = WAIT;
                        cnt_next   = 4'(MEM_LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    stall    = 1'b1;
                    cnt_next = cnt - 4'd1;
                end else begin
                    // inputs are held during the wait, so the access is re-qualified here
                    mem_op     = access & aligned;
                    state_next = IDLE;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        rd_byte  = rd_word[{alu_res[1:0], 3'b000} +: 8];
        rd_half  = alu_res[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = 32'd0;
        if (mem_op && mem_r_en) begin
            case (size)
                2'b00:   load_val = load_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
                2'b01:   load_val = load_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
                default: load_val = rd_word;
            endcase
        end
    end

    always_comb begin
        wr_data = st_value;
        be      = 4'b1111;
        case (size)
            2'b00: begin
                wr_data = {4{st_value[7:0]}};
                be      = 4'b0001 << alu_res[1:0];
            end
            2'b01: begin
                wr_data = {2{st_value[15:0]}};
                be      = alu_res[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_data = st_value;
                be      = 4'b1111;
            end
        endcase
    end

    // NOTE: the data array is deliberately not reset; its contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_op && mem_w_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // A stalled cycle registers a bubble; datapath outputs keep their last values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
            misalign_out <= 1'b0;
            pc_out       <= 32'd0;
            alu_res_out  <= 32'd0;
            mem_data_out <= 32'd0;
            dest_out     <= '0;
        end else if (stall) begin
            out_valid    <= 1'b0;
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
            misalign_out <= 1'b0;
        end else begin
            out_valid    <= in_valid;
            wb_en_out    <= in_valid & wb_en & ~misaligned;
            mem_r_en_out <= mem_r_en;
            misalign_out <= misaligned;
            pc_out       <= pc;
            alu_res_out  <= alu_res;
            mem_data_out <= load_val;
            dest_out     <= dest;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: one instance with MEM_LATENCY=2 and
// one with MEM_LATENCY=0, directed vectors with hand-computed results.
module tb_mem_access_unit;

    localparam int DW = 5;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   pc_ctr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic          a_in_valid, a_wb_en, a_rd, a_wr, a_uns;
    logic [1:0]    a_size;
    logic [31:0]   a_pc, a_addr, a_st;
    logic [DW-1:0] a_dest;
    logic          a_stall, a_out_valid, a_wb_out, a_rd_out, a_mis_out;
    logic [31:0]   a_pc_out, a_alu_out, a_data_out;
    logic [DW-1:0] a_dest_out;

    logic          z_in_valid, z_wb_en, z_rd, z_wr, z_uns;
    logic [1:0]    z_size;
    logic [31:0]   z_pc, z_addr, z_st;
    logic [DW-1:0] z_dest;
    logic          z_stall, z_out_valid, z_wb_out, z_rd_out, z_mis_out;
    logic [31:0]   z_pc_out, z_alu_out, z_data_out;
    logic [DW-1:0] z_dest_out;

    mem_access_unit #(.DEPTH(64), .MEM_LATENCY(2), .DEST_W(DW)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .wb_en(a_wb_en),
        .mem_r_en(a_rd), .mem_w_en(a_wr), .size(a_size), .load_unsigned(a_uns),
        .pc(a_pc), .alu_res(a_addr), .st_value(a_st), .dest(a_dest),
        .stall(a_stall), .out_valid(a_out_valid), .wb_en_out(a_wb_out),
        .mem_r_en_out(a_rd_out), .misalign_out(a_mis_out), .pc_out(a_pc_out),
        .alu_res_out(a_alu_out), .mem_data_out(a_data_out), .dest_out(a_dest_out)
    );

    mem_access_unit #(.DEPTH(64), .MEM_LATENCY(0), .DEST_W(DW)) dut_z (
        .clk(clk), .rst(rst), .in_valid(z_in_valid), .wb_en(z_wb_en),
        .mem_r_en(z_rd), .mem_w_en(z_wr), .size(z_size), .load_unsigned(z_uns),
        .pc(z_pc), .alu_res(z_addr), .st_value(z_st), .dest(z_dest),
        .stall(z_stall), .out_valid(z_out_valid), .wb_en_out(z_wb_out),
        .mem_r_en_out(z_rd_out), .misalign_out(z_mis_out), .pc_out(z_pc_out),
        .alu_res_out(z_alu_out), .mem_data_out(z_data_out), .dest_out(z_dest_out)
    );

    typedef struct {
        logic        chk_data;
        logic [31:0] data;
        logic        wb;
        logic        mis;
        logic [31:0] pc;
        int          due;
    } exp_t;

    exp_t q_a[$];
    exp_t q_z[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (a_out_valid) begin
            if (q_a.size() == 0) begin
                check("a_spurious_out", {31'd0, a_out_valid}, 32'd0);
            end else begin
                e = q_a.pop_front();
                check("a_pc", a_pc_out, e.pc);
                check("a_cycle", 32'(cyc), 32'(e.due));
                check("a_wb_en_out", {31'd0, a_wb_out}, {31'd0, e.wb});
                check("a_misalign_out", {31'd0, a_mis_out}, {31'd0, e.mis});
                if (e.chk_data) check("a_mem_data_out", a_data_out, e.data);
            end
        end
    end

    always @(negedge clk) begin : mon_z
        exp_t e;
        if (z_out_valid) begin
            if (q_z.size() == 0) begin
                check("z_spurious_out", {31'd0, z_out_valid}, 32'd0);
            end else begin
                e = q_z.pop_front();
                check("z_pc", z_pc_out, e.pc);
                check("z_cycle", 32'(cyc), 32'(e.due));
                check("z_wb_en_out", {31'd0, z_wb_out}, {31'd0, e.wb});
                check("z_misalign_out", {31'd0, z_mis_out}, {31'd0, e.mis});
                if (e.chk_data) check("z_mem_data_out", z_data_out, e.data);
            end
        end
    end

    task automatic idle_inputs();
        a_in_valid = 0; a_wb_en = 0; a_rd = 0; a_wr = 0; a_uns = 0; a_size = 0;
        a_pc = 0; a_addr = 0; a_st = 0; a_dest = 0;
        z_in_valid = 0; z_wb_en = 0; z_rd = 0; z_wr = 0; z_uns = 0; z_size = 0;
        z_pc = 0; z_addr = 0; z_st = 0; z_dest = 0;
    endtask

    // Drives one instruction (z selects the zero-latency instance), queues its
    // expected result and counts stall cycles until the stage accepts it.
    task automatic issue(input bit z, input bit iv, input bit rd, input bit wr, input bit wb,
                         input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                         input logic [31:0] st, input bit chk, input logic [31:0] exp_data,
                         input bit exp_mis);
        exp_t  e;
        int    stalls;
        int    exp_stalls;
        bit    done;
        string nm;
        pc_ctr += 4;
        if (z) begin
            z_in_valid = iv; z_rd = rd; z_wr = wr; z_wb_en = wb; z_size = sz; z_uns = uns;
            z_addr = addr; z_st = st; z_pc = pc_ctr; z_dest = 5'(pc_ctr);
        end else begin
            a_in_valid = iv; a_rd = rd; a_wr = wr; a_wb_en = wb; a_size = sz; a_uns = uns;
            a_addr = addr; a_st = st; a_pc = pc_ctr; a_dest = 5'(pc_ctr);
        end
        exp_stalls = (!z && iv && (rd || wr) && !exp_mis) ? 2 : 0;
        e.chk_data = chk;
        e.data     = exp_data;
        e.wb       = iv & wb & ~exp_mis;
        e.mis      = exp_mis;
        e.pc       = pc_ctr;
        e.due      = cyc + exp_stalls + 1;
        if (iv) begin
            if (z) q_z.push_back(e);
            else   q_a.push_back(e);
        end
        stalls = 0;
        done   = 0;
        for (int k = 0; k < 8 && !done; k++) begin
            @(negedge clk);
            if ((z ? z_stall : a_stall) == 1'b0) begin
                done = 1;
            end else begin
                stalls++;
                @(posedge clk);
            end
        end
        nm = z ? "z_stall_cycles" : "a_stall_cycles";
        check(nm, 32'(stalls), 32'(exp_stalls));
        @(posedge clk);
        #1;
        if (z) begin z_in_valid = 0; z_rd = 0; z_wr = 0; z_wb_en = 0; end
        else   begin a_in_valid = 0; a_rd = 0; a_wr = 0; a_wb_en = 0; end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        rst = 1'b0;
        #2;
        check("a_reset_ctl", {28'd0, a_out_valid, a_wb_out, a_rd_out, a_mis_out}, 32'd0);
        check("a_reset_data", a_pc_out | a_alu_out | a_data_out | 32'(a_dest_out), 32'd0);
        check("z_reset_ctl", {28'd0, z_out_valid, z_wb_out, z_rd_out, z_mis_out}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // latency-2 instance: word store/load, sub-word access, sign handling
        issue(0, 1, 0, 1, 0, 2'd2, 0, 32'h8, 32'h11223344, 0, 32'h0, 0);
        issue(0, 1, 1, 0, 1, 2'd2, 0, 32'h8, 32'h0, 1, 32'h11223344, 0);
        issue(0, 1, 1, 0, 1, 2'd0, 0, 32'hB, 32'h0, 1, 32'h00000011, 0);
        issue(0, 1, 0, 1, 0, 2'd0, 0, 32'h9, 32'h80, 0, 32'h0, 0);
        issue(0, 1, 1, 0, 1, 2'd0, 0, 32'h9, 32'h0, 1, 32'hFFFFFF80, 0);
        issue(0, 1, 1, 0, 1, 2'd0, 1, 32'h9, 32'h0, 1, 32'h00000080, 0);
        issue(0, 1, 1, 0, 1, 2'd1, 1, 32'hA, 32'h0, 1, 32'h00001122, 0);
        issue(0, 1, 1, 0, 1, 2'd1, 0, 32'h8, 32'h0, 1, 32'hFFFF8044, 0);

        // misaligned accesses: no stall, no write, wb suppressed
        issue(0, 1, 1, 0, 1, 2'd2, 0, 32'h6, 32'h0, 1, 32'h0, 1);
        issue(0, 1, 1, 0, 1, 2'd1, 0, 32'h9, 32'h0, 1, 32'h0, 1);
        issue(0, 1, 0, 1, 0, 2'd2, 0, 32'hA, 32'hFFFFFFFF, 1, 32'h0, 1);
        issue(0, 1, 1, 0, 1, 2'd2, 0, 32'h8, 32'h0, 1, 32'h11228044, 0);

        // simultaneous read+write returns the pre-write word
        issue(0, 1, 1, 1, 1, 2'd2, 0, 32'h8, 32'h55, 1, 32'h11228044, 0);
        issue(0, 1, 1, 0, 1, 2'd2, 0, 32'h8, 32'h0, 1, 32'h00000055, 0);

        // reset in the middle of a pending store aborts it
        issue(0, 1, 0, 1, 0, 2'd2, 0, 32'h4, 32'hCAFEF00D, 0, 32'h0, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        a_in_valid = 1; a_wr = 1; a_size = 2'd2; a_addr = 32'h4; a_st = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("a_rst_mid_ctl", {28'd0, a_out_valid, a_wb_out, a_rd_out, a_mis_out}, 32'd0);
        check("a_rst_mid_data", a_pc_out | a_alu_out | a_data_out | 32'(a_dest_out), 32'd0);
        @(negedge clk);
        a_in_valid = 0; a_wr = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        issue(0, 1, 1, 0, 1, 2'd2, 0, 32'h4, 32'h0, 1, 32'hCAFEF00D, 0);

        // address wrap modulo DEPTH*4, and in_valid=0 must not write
        issue(0, 1, 0, 1, 0, 2'd2, 0, 32'h100, 32'hA5A5A5A5, 0, 32'h0, 0);
        issue(0, 1, 1, 0, 1, 2'd2, 0, 32'h0, 32'h0, 1, 32'hA5A5A5A5, 0);
        issue(0, 0, 0, 1, 0, 2'd2, 0, 32'h0, 32'hFFFFFFFF, 0, 32'h0, 0);
        issue(0, 1, 1, 0, 1, 2'd2, 0, 32'h0, 32'h0, 1, 32'hA5A5A5A5, 0);

        // zero-latency instance: one instruction per cycle, never stalls
        issue(1, 1, 0, 1, 0, 2'd2, 0, 32'h10, 32'h01020304, 0, 32'h0, 0);
        issue(1, 1, 1, 0, 1, 2'd2, 0, 32'h10, 32'h0, 1, 32'h01020304, 0);
        issue(1, 1, 0, 1, 0, 2'd1, 0, 32'h12, 32'hBEEF, 0, 32'h0, 0);
        issue(1, 1, 1, 0, 1, 2'd2, 0, 32'h10, 32'h0, 1, 32'hBEEF0304, 0);
        issue(1, 1, 1, 0, 1, 2'd0, 1, 32'h13, 32'h0, 1, 32'h000000BE, 0);
        issue(1, 1, 1, 0, 1, 2'd1, 0, 32'h12, 32'h0, 1, 32'hFFFFBEEF, 0);

        repeat (4) @(negedge clk);
        check("a_queue_drained", 32'(q_a.size()), 32'd0);
        check("z_queue_drained", 32'(q_z.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
